mdu_iter: RTL

- Parametrised, self-contained iterative multiply/divide unit.
- Implements the RV32M MULL/MULH/DIV/REM operations, including the signed/unsigned variants selected by signed_a/signed_b.
- Has its own adder/shifter datapath rather than borrowing the ALU.
- Sits beside the ALU in EXU; takes requests over a valid/ready handshake and returns one tagged result per request.

---
 rtl/mdu_iter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M multiply/divide unit (radix-2^MUL_STEP shift-add multiply, restoring divide).
// Optional macro MDU_EARLY_OUT_EN adds accept-time shortcuts for zero multiplies and |a| < |b| divides.
module mdu_iter #(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 2,
    parameter int TAG_W    = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic             in_signed_a,
    input  logic             in_signed_b,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    localparam int            CW    = $clog2(XLEN + 1);
    localparam int            PW    = XLEN + MUL_STEP;
    localparam logic [CW-1:0] K_MUL = CW'(XLEN / MUL_STEP);
    localparam logic [CW-1:0] K_DIV = CW'(XLEN);
    localparam logic [1:0]    OP_MULL = 2'd0, OP_MULH = 2'd1, OP_DIV = 2'd2;

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]     cnt;
    logic [1:0]        op;
    logic              neg;
    logic [TAG_W-1:0]  tag;
    logic [2*XLEN-1:0] acc;   // mul: {partial product, multiplier}; div: low half = dividend/quotient
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   opnd;  // mul: |a| multiplicand; div: |b| divisor

    logic accept;
    assign in_ready  = (state == IDLE) && !flush;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    logic            a_neg, b_neg, is_div, div0, ovf, early;
    logic [XLEN-1:0] a_mag, b_mag;
    assign a_neg  = in_signed_a && in_a[XLEN-1];
    assign b_neg  = in_signed_b && in_b[XLEN-1];
    assign a_mag  = a_neg ? -in_a : in_a;
    assign b_mag  = b_neg ? -in_b : in_b;
    assign is_div = in_op[1];
    assign div0   = is_div && (in_b == '0);
    assign ovf    = is_div && in_signed_a && in_signed_b &&
                    (in_a == {1'b1, {(XLEN-1){1'b0}}}) && (&in_b);
`ifdef MDU_EARLY_OUT_EN
    assign early  = is_div ? (a_mag < b_mag) : ((in_a == '0) || (in_b == '0));
`else
    assign early  = 1'b0;
`endif

    // one multiply step: add opnd * (next MUL_STEP multiplier bits) into the upper half
    logic [PW-1:0] pp, msum;
    always_comb begin
        pp = '0;
        for (int i = 0; i < MUL_STEP; i++)
            if (acc[i]) pp = pp + (PW'(opnd) << i);
        msum = PW'(acc[2*XLEN-1:XLEN]) + pp;
    end

    // one restoring divide step on the XLEN+1 bit shifted partial remainder
    logic [XLEN:0]   rsh;
    logic [XLEN-1:0] rsub;
    logic            qbit;
    always_comb begin
        rsh  = {rem, acc[XLEN-1]};
        qbit = (rsh >= {1'b0, opnd});
        rsub = rsh[XLEN-1:0] - opnd;
    end

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rmd, res;
    always_comb begin
        prod = neg ? -acc : acc;
        quo  = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rmd  = neg ? -rem : rem;
        case (op)
            OP_MULL: res = prod[XLEN-1:0];
            OP_MULH: res = prod[2*XLEN-1:XLEN];
            OP_DIV:  res = quo;
            default: res = rmd;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (div0 || ovf || early) ? FIXUP : CALC;
            CALC:    if (cnt == CW'(1)) state_nxt = FIXUP;
            FIXUP:   state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= '0;
            op         <= '0;
            neg        <= 1'b0;
            tag        <= '0;
            acc        <= '0;
            rem        <= '0;
            opnd       <= '0;
            out_result <= '0;
            out_tag    <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op  <= in_op;
                    tag <= in_tag;
                    cnt <= is_div ? K_DIV : K_MUL;
                    if (!is_div) begin
                        neg  <= a_neg ^ b_neg;
                        opnd <= a_mag;
                        acc  <= early ? '0 : {{XLEN{1'b0}}, b_mag};
                        rem  <= '0;
                    end else begin
                        // a zero divisor reports all ones unsigned, so its DIV sign is forced clear
                        neg  <= in_op[0] ? a_neg : (!div0 && (a_neg ^ b_neg));
                        opnd <= b_mag;
                        acc  <= {{XLEN{1'b0}}, div0 ? {XLEN{1'b1}} : (early ? {XLEN{1'b0}} : a_mag)};
                        rem  <= (div0 || early) ? a_mag : '0;
                    end
                end
                CALC: begin
                    cnt <= cnt - CW'(1);
                    if (!op[1]) begin
                        acc <= {msum, acc[XLEN-1:MUL_STEP]};
                    end else begin
                        acc[XLEN-1:0] <= {acc[XLEN-2:0], qbit};
                        rem           <= qbit ? rsub : rsh[XLEN-1:0];
                    end
                end
                FIXUP: if (!flush) begin
                    out_result <= res;
                    out_tag    <= tag;
                end
                default: ;
            endcase
        end
    end
endmodule
